// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and constants for the neuron sequencer
// Purpose: FSM state encoding, FP32 width and the FP32 +0.0 constant.
// Ports: none (package).
package neuron_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MAC,
    S_BIAS,
    S_OUT
  } state_e;

endpackage

// File: rtl/float_adder.sv
// rtl/float_adder.sv - combinational FP32 adder, round-to-nearest-even
// Purpose: y = a + b for normal operands with guard/round/sticky rounding;
//          subnormals flush to zero, exact cancellation yields +0.0.
// Ports: a, b - FP32 operands; y - FP32 sum.
module float_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        swap, sub, found, rnd, uflow;
  logic [31:0] x, z;
  logic [7:0]  d;
  logic [26:0] mx, mz, mz_sh, lost_mask, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic [23:0] frac_r;

  always_comb begin
    // x is the larger magnitude, so the aligned difference never goes negative.
    swap = (b[30:0] > a[30:0]);
    x    = swap ? b : a;
    z    = swap ? a : b;
    sub  = x[31] ^ z[31];
    d    = x[30:23] - z[30:23];
    // Mantissa layout: hidden bit, 23 fraction bits, guard, round, sticky.
    mx   = {1'b1, x[22:0], 3'b000};
    mz   = (z[30:23] == 8'd0) ? 27'd0 : {1'b1, z[22:0], 3'b000};
    lost_mask = '0;
    if (d >= 8'd27) begin
      mz_sh = {26'd0, |mz};
    end else begin
      lost_mask = (27'd1 << d) - 27'd1;
      mz_sh     = (mz >> d) | {26'd0, |(mz & lost_mask)};
    end
    sum = sub ? ({1'b0, mx} - {1'b0, mz_sh}) : ({1'b0, mx} + {1'b0, mz_sh});

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 5'd1;
      end
    end

    e     = {2'b00, x[30:23]};
    uflow = 1'b0;
    if (sum[27]) begin
      norm = {sum[27:2], |sum[1:0]};
      e    = e + 10'd1;
    end else begin
      norm  = sum[26:0] << lz;
      e     = e - {5'd0, lz};
      uflow = ({3'd0, lz} >= x[30:23]);
    end

    rnd    = norm[2] & (norm[3] | norm[1] | norm[0]);
    frac_r = {1'b0, norm[25:3]} + {23'd0, rnd};
    if (frac_r[23]) e = e + 10'd1;

    y = {x[31], e[7:0], frac_r[22:0]};
    if (e >= 10'd255) y = {x[31], 8'hFF, 23'd0};
    // A cleared hidden bit after normalisation means the sum was exactly zero.
    if (!norm[26])  y = 32'd0;
    else if (uflow) y = {x[31], 31'd0};
    if (x[30:23] == 8'd0) y = {a[31] & b[31], 31'd0};
  end

endmodule

// File: rtl/float_mult.sv
// rtl/float_mult.sv - combinational FP32 multiplier, round-to-nearest-even
// Purpose: y = a * b for normal operands; subnormal inputs and underflowing
//          results flush to signed zero, overflow saturates to infinity.
// Ports: a, b - FP32 operands; y - FP32 product.
module float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [47:0] prod;
  logic [9:0]  e;
  logic [9:0]  e_out;
  logic [22:0] frac;
  logic [23:0] frac_r;
  logic        g, s, rnd, sign;

  always_comb begin
    sign = a[31] ^ b[31];
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    // Sum of biased exponents; the bias is removed once below.
    e    = {2'b00, a[30:23]} + {2'b00, b[30:23]};
    if (prod[47]) begin
      frac = prod[46:24];
      g    = prod[23];
      s    = |prod[22:0];
      e    = e + 10'd1;
    end else begin
      frac = prod[45:23];
      g    = prod[22];
      s    = |prod[21:0];
    end
    rnd    = g & (s | frac[0]);
    frac_r = {1'b0, frac} + {23'd0, rnd};
    // Rounding 1.111..1 up carries into the exponent; fraction is already 0.
    if (frac_r[23]) e = e + 10'd1;
    // e_out is never below -127, so bit 9 doubles as a sign bit.
    e_out = e - 10'd127;
    y = {sign, e_out[7:0], frac_r[22:0]};
    if (!e_out[9] && (e_out[8:0] >= 9'd255)) y = {sign, 8'hFF, 23'd0};
    if (e_out[9] || (e_out == 10'd0)) y = {sign, 31'd0};
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) y = {sign, 31'd0};
  end

endmodule

// File: rtl/neuron_mac_dp.sv
// rtl/neuron_mac_dp.sv - multiply-accumulate datapath for the neuron sequencer
// Purpose: sum = acc + (sel_bias ? bias : act * wt), purely combinational.
// Ports: acc, act, wt, bias - FP32 operands; sel_bias - addend select;
//        sum - FP32 result fed back into the controller's accumulator.
module neuron_mac_dp
  import neuron_pkg::*;
(
  input  logic [FP_W-1:0] acc,
  input  logic [FP_W-1:0] act,
  input  logic [FP_W-1:0] wt,
  input  logic [FP_W-1:0] bias,
  input  logic            sel_bias,
  output logic [FP_W-1:0] sum
);

  logic [FP_W-1:0] prod;
  logic [FP_W-1:0] addend;

  float_mult u_mult (
    .a (act),
    .b (wt),
    .y (prod)
  );

  assign addend = sel_bias ? bias : prod;

  float_adder u_add (
    .a (acc),
    .b (addend),
    .y (sum)
  );

endmodule

// File: rtl/neuron_seq_ctrl.sv
// rtl/neuron_seq_ctrl.sv - sequential FP32 neuron evaluation controller
// Purpose: evaluates sum(act[k]*wt[k], k=0..N_IN-1) + bias in strict index
//          order, one MAC per activation transfer, then presents the result.
// Ports: clk, rst (sync, active-high); start/bias - run request and bias;
//        busy - not idle; wt_addr/wt_data - weight ROM (1-cycle latency);
//        act_data/act_valid/act_ready - activation stream;
//        result_data/result_valid/result_ready - result handshake.
// Build option: NEURON_RELU_EN - clamp negative results (incl. -0.0) to +0.0.
module neuron_seq_ctrl
  import neuron_pkg::*;
#(
  parameter int N_IN   = 15,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FP_W-1:0]   bias,
  output logic              busy,
  output logic [ADDR_W-1:0] wt_addr,
  input  logic [FP_W-1:0]   wt_data,
  input  logic [FP_W-1:0]   act_data,
  input  logic              act_valid,
  output logic              act_ready,
  output logic [FP_W-1:0]   result_data,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_IN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [FP_W-1:0]   acc_q, acc_d;
  logic [FP_W-1:0]   bias_q, bias_d;
  logic [FP_W-1:0]   sum;
  logic [FP_W-1:0]   out_val;
  logic              sel_bias;

  neuron_mac_dp u_dp (
    .acc      (acc_q),
    .act      (act_data),
    .wt       (wt_data),
    .bias     (bias_q),
    .sel_bias (sel_bias),
    .sum      (sum)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    wt_addr_d = wt_addr_q;
    acc_d     = acc_q;
    bias_d    = bias_q;
    sel_bias  = 1'b0;
    act_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bias_d    = bias;
          k_d       = '0;
          wt_addr_d = '0;
          acc_d     = FP_ZERO;
          state_d   = S_FETCH;
        end
      end
      // One dead cycle so the ROM output matches wt_addr before the MAC.
      S_FETCH: state_d = S_MAC;
      S_MAC: begin
        act_ready = 1'b1;
        if (act_valid) begin
          acc_d = sum;
          if (k_q == K_LAST) begin
            state_d = S_BIAS;
          end else begin
            k_d       = k_q + ADDR_W'(1);
            wt_addr_d = k_q + ADDR_W'(1);
            state_d   = S_FETCH;
          end
        end
      end
      S_BIAS: begin
        sel_bias = 1'b1;
        acc_d    = sum;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      wt_addr_q <= '0;
      acc_q     <= FP_ZERO;
      bias_q    <= FP_ZERO;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wt_addr_q <= wt_addr_d;
      acc_q     <= acc_d;
      bias_q    <= bias_d;
    end
  end

`ifdef NEURON_RELU_EN
  assign out_val = acc_q[31] ? FP_ZERO : acc_q;
`else
  assign out_val = acc_q;
`endif

  assign busy         = (state_q != S_IDLE);
  assign wt_addr      = wt_addr_q;
  assign result_valid = (state_q == S_OUT);
  // Gated so a partial accumulation is never visible outside OUT.
  assign result_data  = result_valid ? out_val : FP_ZERO;

endmodule

// File: doc/neuron_seq_ctrl.md
NEURON_SEQ_CTRL -- requirements
Module: neuron_seq_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 15: number of inputs per neuron, legal range 1..64.
REQ-002 SHALL have parameter ADDR_W, default 4: weight address width, with 2**ADDR_W >= N_IN.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request one neuron evaluation; sampled only in IDLE.
REQ-006 SHALL have port bias, input, 32 bits: IEEE-754 single-precision bias; sampled on start acceptance.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port wt_addr, output, ADDR_W bits: weight ROM address, registered.
REQ-009 SHALL have port wt_data, input, 32 bits: FP32 weight; valid one cycle after wt_addr changes.
REQ-010 SHALL have ports act_data (input, 32 bits, FP32 activation), act_valid (input, 1 bit) and act_ready (output, 1 bit): activation stream handshake.
REQ-011 SHALL have ports result_data (output, 32 bits), result_valid (output, 1 bit) and result_ready (input, 1 bit): result handshake.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, MAC, BIAS and OUT.
REQ-013 IDLE: on start=1, SHALL latch bias, set k=0, acc=32'h00000000, wt_addr=0, and go to FETCH; otherwise stay in IDLE.
REQ-014 FETCH: SHALL last exactly one cycle (weight read latency), with act_ready=0, then go to MAC.
REQ-015 MAC: SHALL assert act_ready=1; on act_valid&act_ready, acc <= acc + act_data*wt_data (float_mult then float_adder).
REQ-016 MAC transfer with k<N_IN-1: k <= k+1, wt_addr <= k+1, next state FETCH.
REQ-017 MAC transfer with k==N_IN-1: next state BIAS.
REQ-018 MAC with act_valid=0: SHALL stall, holding acc, k and wt_addr.
REQ-019 BIAS: acc <= acc + bias_latched; one cycle; then go to OUT.
REQ-020 OUT: result_valid=1 and result_data=f(acc), both held stable until result_ready=1; on handshake, go to IDLE.
REQ-021 start asserted while busy=1 SHALL be ignored (no queuing).
REQ-022 Latency with act_valid held high: start accepted in cycle 0, result_valid first high in cycle 2*N_IN+2.
REQ-023 N_IN=1: FETCH, MAC, BIAS, OUT in sequence; there SHALL be no special case.
REQ-024 Accumulation order SHALL be strictly index 0..N_IN-1, then bias, so results are bit-reproducible.

Reset
REQ-025 rst=1 SHALL, in any state including mid-accumulation or OUT, force IDLE on the next edge.
REQ-026 That reset SHALL set busy=0, act_ready=0, result_valid=0, result_data=0, wt_addr=0, k=0, acc=0 and bias_latched=0.
REQ-027 A partial accumulation interrupted by reset SHALL never appear on result_data.

Configuration
REQ-028 Macro NEURON_RELU_EN defined: f(acc) = acc if acc[31]==0, else 32'h00000000 (this includes -0.0).
REQ-029 Macro NEURON_RELU_EN undefined: f(acc) = acc unchanged.

Structure
REQ-030 Package neuron_pkg SHALL hold the FSM state typedef, FP_ZERO=32'h00000000 and the FP32 width constant.
REQ-031 Sub-module neuron_mac_dp SHALL contain one float_mult and one float_adder, with an addend-select input that chooses product vs. bias.
REQ-032 The controller SHALL own the FSM, counter and registers only.

Verification
REQ-033 With N_IN=2, act={3F800000, 40000000}, wt={3F000000, 3E800000}, bias=3E800000 and continuous valid -> result_data=3FA00000 (1.25), with result_valid first high in cycle 6.
REQ-034 Same stimulus but wt={BF800000, BF800000} -> result_data=00000000 with NEURON_RELU_EN defined, and C0300000 (-2.75) without it.
REQ-035 act_valid low for 3 cycles inside MAC -> act_ready stays 1, acc and wt_addr are unchanged, and the final result is identical to REQ-033 with latency +3.
REQ-036 result_ready held low for 5 cycles in OUT, with start pulsed meanwhile -> result_data stable, no new run, and busy stays 1 until the handshake.
REQ-037 rst pulsed at k=1 in MAC -> next cycle busy=0 and result_valid=0; a fresh start then reproduces the REQ-033 result exactly.
REQ-038 N_IN=1, act=40400000, wt=3F800000, bias=00000000 -> result_data=40400000 in cycle 4.
